// File: rtl/rf_fwd_stage.sv
// Register-fetch stage: architectural register file plus operand forwarding, load-use interlock and valid/ready output.
// Optional macro RF_FWD_STALL_CNT_EN adds a saturating 32-bit stall_cnt output.

// Resolves one source operand against the forwarding entries, same-cycle writeback and the register file.
module rf_fwd_operand #(
    parameter int LANES  = 2,
    parameter int DEPTH  = 7,
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7
) (
    input  logic [ADDR_W-1:0]                    i_addr,
    input  logic [LANES*DEPTH-1:0]               i_st_wr,
    input  logic [LANES*DEPTH-1:0]               i_st_rdy,
    input  logic [LANES*DEPTH-1:0][ADDR_W-1:0]   i_st_dst,
    input  logic [LANES*DEPTH-1:0][DATA_W-1:0]   i_st_data,
    input  logic [LANES-1:0]                     i_wb_en,
    input  logic [LANES-1:0][ADDR_W-1:0]         i_wb_addr,
    input  logic [LANES-1:0][DATA_W-1:0]         i_wb_data,
    input  logic [DATA_W-1:0]                    i_rf_data,
    output logic [DATA_W-1:0]                    o_data,
    output logic                                 o_pend
);
    logic              w_st_hit;
    logic              w_st_rdy;
    logic [DATA_W-1:0] w_st_val;
    logic              w_wb_hit;
    logic [DATA_W-1:0] w_wb_val;

    // Walk oldest-to-youngest so the last hit (youngest stage, highest lane) wins.
    always_comb begin
        w_st_hit = 1'b0;
        w_st_rdy = 1'b0;
        w_st_val = '0;
        for (int s = DEPTH-1; s >= 0; s--) begin
            for (int l = 0; l < LANES; l++) begin
                if (i_st_wr[s*LANES+l] && i_st_dst[s*LANES+l] == i_addr) begin
                    w_st_hit = 1'b1;
                    w_st_rdy = i_st_rdy[s*LANES+l];
                    w_st_val = i_st_data[s*LANES+l];
                end
            end
        end
    end

    always_comb begin
        w_wb_hit = 1'b0;
        w_wb_val = '0;
        for (int l = 0; l < LANES; l++) begin
            if (i_wb_en[l] && i_wb_addr[l] == i_addr) begin
                w_wb_hit = 1'b1;
                w_wb_val = i_wb_data[l];
            end
        end
    end

    assign o_data = w_st_hit ? w_st_val : (w_wb_hit ? w_wb_val : i_rf_data);
    assign o_pend = w_st_hit && !w_st_rdy;
endmodule

module rf_fwd_stage #(
    parameter int LANES  = 2,
    parameter int SRCS   = 3,
    parameter int DEPTH  = 7,
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7,
    parameter int INFO_W = 112
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [LANES*INFO_W-1:0]                     in_info,
    input  logic [LANES*SRCS*ADDR_W-1:0]                src_addr,
    input  logic [LANES*SRCS-1:0]                       src_used,
    input  logic [LANES*DEPTH*(2+ADDR_W+DATA_W)-1:0]    stg_bus,
    input  logic [LANES-1:0]                            wb_en,
    input  logic [LANES*ADDR_W-1:0]                     wb_addr,
    input  logic [LANES*DATA_W-1:0]                     wb_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [LANES*INFO_W-1:0]                     out_info,
    output logic [LANES*SRCS*DATA_W-1:0]                out_data,
    output logic                                        hazard
`ifdef RF_FWD_STALL_CNT_EN
    ,
    output logic [31:0]                                 stall_cnt
`endif
);
    localparam int NREGS = 2**ADDR_W;
    localparam int ENT_W = 2 + ADDR_W + DATA_W;
    localparam int NENT  = LANES * DEPTH;
    localparam int NOPS  = LANES * SRCS;

    logic [DATA_W-1:0]               r_rf [NREGS];
    logic                            r_out_valid;
    logic [LANES*INFO_W-1:0]         r_out_info;
    logic [NOPS-1:0][DATA_W-1:0]     r_out_data;

    logic [NENT-1:0]                 w_st_wr;
    logic [NENT-1:0]                 w_st_rdy;
    logic [NENT-1:0][ADDR_W-1:0]     w_st_dst;
    logic [NENT-1:0][DATA_W-1:0]     w_st_data;
    logic [LANES-1:0][ADDR_W-1:0]    w_wb_addr;
    logic [LANES-1:0][DATA_W-1:0]    w_wb_data;
    logic [NOPS-1:0][ADDR_W-1:0]     w_src_addr;
    logic [NOPS-1:0][DATA_W-1:0]     w_rf_rd;
    logic [NOPS-1:0][DATA_W-1:0]     w_res;
    logic [NOPS-1:0]                 w_pend;
    logic                            w_hazard;
    logic                            w_in_ready;
    logic                            w_accept;

    assign w_wb_addr  = wb_addr;
    assign w_wb_data  = wb_data;
    assign w_src_addr = src_addr;

    // Entry e = (stage-1)*LANES + lane; each entry is {wr, rdy, dst, data}, wr in the MSB.
    for (genvar e = 0; e < NENT; e++) begin : g_ent
        assign w_st_wr[e]   = stg_bus[e*ENT_W + DATA_W + ADDR_W + 1];
        assign w_st_rdy[e]  = stg_bus[e*ENT_W + DATA_W + ADDR_W];
        assign w_st_dst[e]  = stg_bus[e*ENT_W + DATA_W +: ADDR_W];
        assign w_st_data[e] = stg_bus[e*ENT_W +: DATA_W];
    end

    // Operand k = lane*SRCS + src.
    for (genvar k = 0; k < NOPS; k++) begin : g_op
        assign w_rf_rd[k] = r_rf[w_src_addr[k]];
        rf_fwd_operand #(
            .LANES  (LANES),
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_op (
            .i_addr    (w_src_addr[k]),
            .i_st_wr   (w_st_wr),
            .i_st_rdy  (w_st_rdy),
            .i_st_dst  (w_st_dst),
            .i_st_data (w_st_data),
            .i_wb_en   (wb_en),
            .i_wb_addr (w_wb_addr),
            .i_wb_data (w_wb_data),
            .i_rf_data (w_rf_rd[k]),
            .o_data    (w_res[k]),
            .o_pend    (w_pend[k])
        );
    end

    assign w_hazard   = |(w_pend & src_used);
    assign w_in_ready = (!r_out_valid || out_ready) && !w_hazard;
    assign w_accept   = in_valid && w_in_ready;

    // Later lanes overwrite earlier ones on an address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (wb_en[l]) r_rf[w_wb_addr[l]] <= w_wb_data[l];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_info  <= '0;
            r_out_data  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_info  <= in_info;
            r_out_data  <= w_res;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef RF_FWD_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (in_valid && w_hazard && r_stall_cnt != 32'hFFFF_FFFF) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign in_ready  = w_in_ready;
    assign hazard    = w_hazard;
    assign out_valid = r_out_valid;
    assign out_info  = r_out_info;
    assign out_data  = r_out_data;
endmodule

// File: doc/rf_fwd_stage.md
Name: rf_fwd_stage

Overview:
Parametrised register-fetch stage for the dual-issue SPU pipeline, placed between decode and the even/odd execution pipes. It holds the architectural register file, reads SRCS operands per lane and resolves them against in-flight results across DEPTH execute stages on every lane. It adds what the fixed two-lane fetch stage lacked: a valid/ready handshake, a load-use interlock for results that are not yet computed, and same-cycle write-through from writeback.

Parameters:
LANES, 2, issue lanes (lane 0 = even, lane 1 = odd; higher index is later in program order)
SRCS, 3, source operands per lane (ra, rb, rc)
DEPTH, 7, forwardable execute stages per lane (stage 1 = youngest)
DATA_W, 128, register width
ADDR_W, 7, register address width; NREGS = 2**ADDR_W
INFO_W, 112, opaque per-lane decode bundle carried through unchanged (instr, id, dst, unit, latency, immediates)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  decode bundle valid
in_ready  out  1  stage accepts the bundle this cycle
in_info  in  LANES*INFO_W  per-lane decode bundle
src_addr  in  LANES*SRCS*ADDR_W  source register addresses
src_used  in  LANES*SRCS  source is actually read by the instruction
stg_bus  in  LANES*DEPTH*(2+ADDR_W+DATA_W)  per-entry fields {wr, rdy, dst[ADDR_W], data[DATA_W]}
wb_en  in  LANES  writeback enables
wb_addr  in  LANES*ADDR_W  writeback addresses
wb_data  in  LANES*DATA_W  writeback data
out_valid  out  1  output bundle valid
out_ready  in  1  execute stage accepts the output bundle
out_info  out  LANES*INFO_W  registered copy of in_info
out_data  out  LANES*SRCS*DATA_W  registered resolved operands
hazard  out  1  combinational: an interlock is blocking in_ready this cycle

Behaviour:
- Reset (rst=0, async): out_valid=0, out_info=0, out_data=0, every register file entry = 0, stall counter = 0.
- Clocking: a single clk domain; all state updates on the rising edge.
- Register file: NREGS x DATA_W, LANES write ports. Writes commit on the clock edge when wb_en[i]=1. When several ports write the same address in one cycle, the highest lane index wins.
- Operand resolution per (lane L, source S): scan stages 1..DEPTH, youngest first. Within one stage, scan lanes from the highest index down. An entry matches when wr=1 and dst == src_addr.
- Result of the first match: if rdy=1, the operand is the entry's data. If rdy=0, the operand is pending.
- No stage match: take wb_data from a same-cycle writeback to that address (highest lane wins). Otherwise take the register file contents.
- Register 0 is ordinary; there is no hardwired zero.
- hazard = 1 when any source with src_used=1 is pending. A pending source with src_used=0 is ignored; its operand is whatever the resolution above gives.
- Handshake: in_ready = (!out_valid || out_ready) && !hazard. Accept = in_valid && in_ready.
- On accept: out_info and out_data load the resolved values, and out_valid is 1 on the next cycle. Latency is one cycle.
- On out_valid && out_ready without an accept: out_valid goes to 0, and out_info/out_data hold their last values.
- While out_valid=1 and out_ready=0, the outputs hold stable. Operands are sampled at accept and never re-resolved.
- A stalled bundle is re-resolved every cycle until accepted. Stage entries advance independently of this block's stall.
- Reset asserted mid-transfer: the pending output is dropped (out_valid=0); no partial register-file write occurs.

Optional Feature:
- Macro RF_FWD_STALL_CNT_EN.
- When defined: adds output stall_cnt (32 bits). It increments on every cycle with in_valid && hazard, saturates at 0xFFFFFFFF, and resets to 0.
- When undefined: the port and the counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then write r5 = 0xAA..AA via wb lane 0; next cycle read r5 on lane 1 src 0 with no stage matches -> out_data = 0xAA..AA with out_valid 1 cycle after accept.
- Same-cycle write-through: wb lane 1 writes r9 = 0x1234 while lane 0 ra = r9 -> ra operand = 0x1234.
- Youngest-stage priority: stage 2 lane 0 {wr=1, rdy=1, dst=r3, data=0x22} and stage 5 lane 1 {wr=1, rdy=1, dst=r3, data=0x55}; lane 0 rb = r3 -> 0x22.
- Same-stage lane priority: stage 1, both lanes dst=r7, data 0x10 (lane 0) and 0x11 (lane 1) -> operand 0x11.
- Interlock: stage 1 {wr=1, rdy=0, dst=r4}; rc = r4 with src_used=1 -> hazard=1, in_ready=0 for 3 cycles; then rdy=1 with data 0x44 -> accept, operand 0x44; with RF_FWD_STALL_CNT_EN, stall_cnt = 3.
- Interlock ignored when unused: same as above but src_used=0 -> no stall.
- Backpressure: out_ready=0 for 4 cycles with out_valid=1 -> in_ready=0 and out_data stable; out_ready=1 -> the next bundle is accepted the same cycle with no bubble.
